// File: rtl/hc299.sv
// hc299 - 8-bit universal shift/storage register with 3-state parallel I/O,
// pin-compatible with the 74HC299 (power pins p10/p20 not modelled).
//
// Ports (package pin numbering):
//   p12  CP    clock, rising edge
//   p9   MR    asynchronous master reset, active-low, clears Q
//   p1   S0    mode select bit 0
//   p19  S1    mode select bit 1
//   p2   OE1   output enable 1, active-low
//   p3   OE2   output enable 2, active-low
//   p11  DSR   serial in for shift-right (enters at Q0)
//   p18  DSL   serial in for shift-left (enters at Q7)
//   p7,p13,p6,p14,p5,p15,p4,p16  I/O0..I/O7 (3-state, bidirectional)
//   p8   Q0    always-driven copy of Q[0]
//   p17  Q7    always-driven copy of Q[7]
//
// INIT sets the power-up register content (simulation/FPGA only).

module hc299 #(
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic p12,
  input  logic p9,
  input  logic p1,
  input  logic p19,
  input  logic p2,
  input  logic p3,
  input  logic p11,
  input  logic p18,
  inout  wire  p7,
  inout  wire  p13,
  inout  wire  p6,
  inout  wire  p14,
  inout  wire  p5,
  inout  wire  p15,
  inout  wire  p4,
  inout  wire  p16,
  output logic p8,
  output logic p17
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  mode_t       mode;
  logic [7:0]  q = INIT;
  logic [7:0]  pin_in;
  logic        drive;

  assign mode   = mode_t'({p19, p1});
  assign pin_in = {p16, p4, p15, p5, p14, p6, p13, p7};

  // Load mode always releases the bus so the external driver never fights us.
  assign drive = !p2 && !p3 && (mode != MODE_LOAD);

  always_ff @(posedge p12 or negedge p9) begin
    if (!p9) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_HOLD: q <= q;
        MODE_SHR:  q <= {q[6:0], p11};
        MODE_SHL:  q <= {p18, q[7:1]};
        MODE_LOAD: q <= pin_in;
        default:   q <= q;
      endcase
    end
  end

  assign p7  = drive ? q[0] : 1'bz;
  assign p13 = drive ? q[1] : 1'bz;
  assign p6  = drive ? q[2] : 1'bz;
  assign p14 = drive ? q[3] : 1'bz;
  assign p5  = drive ? q[4] : 1'bz;
  assign p15 = drive ? q[5] : 1'bz;
  assign p4  = drive ? q[6] : 1'bz;
  assign p16 = drive ? q[7] : 1'bz;

  assign p8  = q[0];
  assign p17 = q[7];

endmodule

// File: tb/tb_hc299.sv
// tb_hc299 - directed self-checking bench for hc299: power-up content, async
// reset, shift right/left, parallel load with bus release, output enables,
// hold, mid-sequence reset and a two-stage right-shift cascade.

module tb_hc299;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // main DUT
  logic mr = 1'b1, s0 = 1'b0, s1 = 1'b0, oe1 = 1'b0, oe2 = 1'b0;
  logic dsr = 1'b0, dsl = 1'b0;
  logic       tb_en  = 1'b0;
  logic [7:0] tb_drv = 8'h00;
  wire io0, io1, io2, io3, io4, io5, io6, io7;
  wire q0, q7;

  assign io0 = tb_en ? tb_drv[0] : 1'bz;
  assign io1 = tb_en ? tb_drv[1] : 1'bz;
  assign io2 = tb_en ? tb_drv[2] : 1'bz;
  assign io3 = tb_en ? tb_drv[3] : 1'bz;
  assign io4 = tb_en ? tb_drv[4] : 1'bz;
  assign io5 = tb_en ? tb_drv[5] : 1'bz;
  assign io6 = tb_en ? tb_drv[6] : 1'bz;
  assign io7 = tb_en ? tb_drv[7] : 1'bz;

  wire [7:0] io = {io7, io6, io5, io4, io3, io2, io1, io0};

  hc299 #(.INIT(8'hA5)) dut (
    .p12(clk), .p9(mr), .p1(s0), .p19(s1), .p2(oe1), .p3(oe2),
    .p11(dsr), .p18(dsl),
    .p7(io0), .p13(io1), .p6(io2), .p14(io3),
    .p5(io4), .p15(io5), .p4(io6), .p16(io7),
    .p8(q0), .p17(q7)
  );

  // cascade pair: stage A p17 feeds stage B p11
  logic mr_a = 1'b0, mr_b = 1'b0, cs0 = 1'b0, cs1 = 1'b0, cdsr = 1'b0;
  wire a0, a1, a2, a3, a4, a5, a6, a7;
  wire b0, b1, b2, b3, b4, b5, b6, b7;
  wire a_q0, a_q7, b_q0, b_q7;
  wire [7:0] ioa = {a7, a6, a5, a4, a3, a2, a1, a0};
  wire [7:0] iob = {b7, b6, b5, b4, b3, b2, b1, b0};

  hc299 #(.INIT(8'h00)) stg_a (
    .p12(clk), .p9(mr_a), .p1(cs0), .p19(cs1), .p2(1'b0), .p3(1'b0),
    .p11(cdsr), .p18(b_q0),
    .p7(a0), .p13(a1), .p6(a2), .p14(a3),
    .p5(a4), .p15(a5), .p4(a6), .p16(a7),
    .p8(a_q0), .p17(a_q7)
  );

  hc299 #(.INIT(8'h00)) stg_b (
    .p12(clk), .p9(mr_b), .p1(cs0), .p19(cs1), .p2(1'b0), .p3(1'b0),
    .p11(a_q7), .p18(1'b0),
    .p7(b0), .p13(b1), .p6(b2), .p14(b3),
    .p5(b4), .p15(b5), .p4(b6), .p16(b7),
    .p8(b_q0), .p17(b_q7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    mr = 1'b0;
    #1;
    mr = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (q0 !== 1'b1) begin bad++; $display("FAIL init_p8 got=%b want=1", q0); end
    total++; if (q7 !== 1'b1) begin bad++; $display("FAIL init_p17 got=%b want=1", q7); end
    total++; if (io !== 8'hA5) begin bad++; $display("FAIL init_io got=%h want=a5", io); end
    mr = 1'b0;
    #1;
    total++; if (q0 !== 1'b0 || q7 !== 1'b0) begin bad++; $display("FAIL async_rst_q0q7 got=%b%b want=00", q0, q7); end
    total++; if (io !== 8'h00) begin bad++; $display("FAIL async_rst_io got=%h want=00", io); end
    s1 = 1'b0; s0 = 1'b1; dsr = 1'b1;
    tick();
    tick();
    total++; if (io !== 8'h00) begin bad++; $display("FAIL rst_held_edges got=%h want=00", io); end
    mr = 1'b1;
    s0 = 1'b0;
    #1;
  endtask

  task automatic test_shift_right();
    logic [7:0] seq;
    seq = 8'b10110010;
    s1 = 1'b0; s0 = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      dsr = seq[i];
      tick();
      if (i == 7) begin
        total++; if (io !== 8'h01) begin bad++; $display("FAIL shr_first got=%h want=01", io); end
      end
    end
    total++; if (io !== 8'hB2) begin bad++; $display("FAIL shr_final got=%h want=b2", io); end
    total++; if (q7 !== 1'b1 || q0 !== 1'b0) begin bad++; $display("FAIL shr_q7q0 got=%b%b want=10", q7, q0); end
    s0 = 1'b0;
  endtask

  task automatic test_mid_reset();
    s1 = 1'b0; s0 = 1'b1; dsr = 1'b1;
    tick();
    total++; if (io !== 8'h65) begin bad++; $display("FAIL midrst_shift got=%h want=65", io); end
    pulse_reset();
    total++; if (io !== 8'h00) begin bad++; $display("FAIL midrst_clear got=%h want=00", io); end
    tick();
    total++; if (io !== 8'h01) begin bad++; $display("FAIL midrst_resume got=%h want=01", io); end
    s0 = 1'b0; dsr = 1'b0;
  endtask

  task automatic test_shift_left();
    pulse_reset();
    s1 = 1'b1; s0 = 1'b0; dsl = 1'b1;
    tick();
    total++; if (io !== 8'h80) begin bad++; $display("FAIL shl_first got=%h want=80", io); end
    tick();
    tick();
    total++; if (io !== 8'hE0) begin bad++; $display("FAIL shl_three got=%h want=e0", io); end
    total++; if (q7 !== 1'b1 || q0 !== 1'b0) begin bad++; $display("FAIL shl_q7q0 got=%b%b want=10", q7, q0); end
    dsl = 1'b0;
    tick();
    total++; if (io !== 8'h70) begin bad++; $display("FAIL shl_zero1 got=%h want=70", io); end
    tick();
    total++; if (io !== 8'h38) begin bad++; $display("FAIL shl_zero2 got=%h want=38", io); end
    s1 = 1'b0;
  endtask

  // With the DUT at Q, the bench drives ~Q; reading back ~Q means the DUT let go.
  task automatic test_load_tristate();
    s1 = 1'b1; s0 = 1'b1;
    tb_drv = 8'hC7; tb_en = 1'b1;
    #1;
    total++; if (io !== 8'hC7) begin bad++; $display("FAIL load_mode_hiz got=%h want=c7", io); end
    tb_drv = 8'h3C;
    tick();
    s1 = 1'b0; s0 = 1'b0; tb_en = 1'b0;
    #1;
    total++; if (io !== 8'h3C) begin bad++; $display("FAIL load_value got=%h want=3c", io); end
    oe1 = 1'b1; tb_drv = 8'hC3; tb_en = 1'b1;
    #1;
    total++; if (io !== 8'hC3) begin bad++; $display("FAIL oe1_hiz got=%h want=c3", io); end
    tb_en = 1'b0;
    #1;
    total++; if (q0 !== 1'b0 || q7 !== 1'b0) begin bad++; $display("FAIL oe1_q0q7 got=%b%b want=00", q0, q7); end
    oe1 = 1'b0;
    #1;
    total++; if (io !== 8'h3C) begin bad++; $display("FAIL oe1_restore got=%h want=3c", io); end
    oe2 = 1'b1; tb_en = 1'b1;
    #1;
    total++; if (io !== 8'hC3) begin bad++; $display("FAIL oe2_hiz got=%h want=c3", io); end
    oe2 = 1'b0; tb_en = 1'b0;
    #1;
  endtask

  task automatic test_hold();
    oe1 = 1'b1; tb_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dsr = i[0]; dsl = ~i[0];
      tb_drv = 8'h5A ^ 8'(i * 37);
      s0 = 1'b1; #1; s1 = 1'b1; #1; s0 = 1'b0; s1 = 1'b0;
      tick();
    end
    tb_en = 1'b0; oe1 = 1'b0;
    #1;
    total++; if (io !== 8'h3C) begin bad++; $display("FAIL hold_value got=%h want=3c", io); end
    total++; if (q0 !== 1'b0 || q7 !== 1'b0) begin bad++; $display("FAIL hold_q0q7 got=%b%b want=00", q0, q7); end
  endtask

  task automatic test_cascade();
    logic [15:0] pat;
    pat = 16'hBEEF;
    mr_a = 1'b1; mr_b = 1'b1;
    cs1 = 1'b0; cs0 = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      cdsr = pat[i];
      tick();
      if (i == 8) begin
        total++; if (ioa !== 8'hBE || iob !== 8'h00) begin bad++; $display("FAIL casc_half got=%h_%h want=00_be", iob, ioa); end
      end
    end
    total++; if (iob !== 8'hBE) begin bad++; $display("FAIL casc_stage2 got=%h want=be", iob); end
    total++; if (ioa !== 8'hEF) begin bad++; $display("FAIL casc_stage1 got=%h want=ef", ioa); end
    total++; if (b_q7 !== 1'b1 || a_q0 !== 1'b1) begin bad++; $display("FAIL casc_pins got=%b%b want=11", b_q7, a_q0); end
    cs0 = 1'b0;
    mr_a = 1'b0;
    #1;
    total++; if (ioa !== 8'h00) begin bad++; $display("FAIL casc_rst_a got=%h want=00", ioa); end
    total++; if (iob !== 8'hBE) begin bad++; $display("FAIL casc_keep_b got=%h want=be", iob); end
    tick();
    total++; if (ioa !== 8'h00 || iob !== 8'hBE) begin bad++; $display("FAIL casc_after_edge got=%h_%h want=be_00", iob, ioa); end
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_mid_reset();
    test_shift_left();
    test_load_tristate();
    test_hold();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
